// File: rtl/sw_seq_feeder.sv
// Loads packed query/database bases into two buffers, streams them symbol by symbol into the
// Smith-Waterman array, then captures its finish/max result and pulses its reset.
module sw_seq_feeder #(
    parameter int SEQ_LEN = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sel,
    input  logic [7:0]  in_data,
    output logic        busy,
    output logic        sw_valid,
    output logic [1:0]  sw_data_s,
    output logic [1:0]  sw_data_t,
    output logic        sw_rst,
    input  logic        sw_finish,
    input  logic [11:0] sw_max,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_max,
    output logic        res_err
);
    localparam int WORDS = SEQ_LEN / 4;
    localparam int AW    = $clog2(WORDS);
    localparam int CNTW  = AW + 1;
    localparam int IDXW  = $clog2(SEQ_LEN);
    localparam int TMOW  = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] LOAD   = 3'd0;
    localparam logic [2:0] STREAM = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] RESULT = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    logic [2:0]      state_reg;
    logic [CNTW-1:0] s_cnt_reg, t_cnt_reg;
    logic [IDXW-1:0] idx_reg;
    logic [TMOW-1:0] tmo_reg;
    logic            sw_valid_reg, sw_rst_reg;
    logic            res_valid_reg, res_err_reg;
    logic [11:0]     res_max_reg;

    logic            s_full, t_full, accept;
    logic [1:0]      wr_en;
    logic [AW-1:0]   wr_addr [2];
    logic [1:0]      rd_sym [2];
    logic [AW-1:0]   rd_word;
    logic [2:0]      rd_off;

    assign s_full   = (s_cnt_reg == CNTW'(WORDS));
    assign t_full   = (t_cnt_reg == CNTW'(WORDS));
    // Ready follows in_sel combinationally so a word for a full buffer stalls rather than drops.
    assign in_ready = (state_reg == LOAD) && (in_sel ? !t_full : !s_full);
    assign accept   = in_valid && in_ready;
    assign wr_en    = {accept && in_sel, accept && !in_sel};
    assign wr_addr[0] = s_cnt_reg[AW-1:0];
    assign wr_addr[1] = t_cnt_reg[AW-1:0];
    assign rd_word  = idx_reg[IDXW-1:2];
    assign rd_off   = {idx_reg[1:0], 1'b0};

    // Buffer 0 holds S, buffer 1 holds T; the symbol register doubles as the RAM read register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        logic [7:0] mem [WORDS];
        logic [1:0] sym_reg;

        always_ff @(posedge clk) begin
            if (wr_en[gi])
                mem[wr_addr[gi]] <= in_data;
        end

        always_ff @(posedge clk) begin
            if (reset)
                sym_reg <= '0;
            else if (state_reg == STREAM)
                sym_reg <= mem[rd_word][rd_off +: 2];
            else
                sym_reg <= '0;
        end

        assign rd_sym[gi] = sym_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= LOAD;
            s_cnt_reg     <= '0;
            t_cnt_reg     <= '0;
            idx_reg       <= '0;
            tmo_reg       <= '0;
            sw_valid_reg  <= 1'b0;
            sw_rst_reg    <= 1'b1;
            res_valid_reg <= 1'b0;
            res_max_reg   <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            sw_valid_reg <= (state_reg == STREAM);
            sw_rst_reg   <= (state_reg == CLEAR);
            case (state_reg)
                LOAD: begin
                    if (wr_en[0])
                        s_cnt_reg <= s_cnt_reg + CNTW'(1);
                    if (wr_en[1])
                        t_cnt_reg <= t_cnt_reg + CNTW'(1);
                    if (s_full && t_full) begin
                        state_reg <= STREAM;
                        idx_reg   <= '0;
                    end
                end
                STREAM: begin
                    idx_reg <= idx_reg + IDXW'(1);
                    if (idx_reg == IDXW'(SEQ_LEN - 1)) begin
                        state_reg <= WAIT;
                        tmo_reg   <= '0;
                    end
                end
                WAIT: begin
                    // A finish on the final timeout cycle still counts as success.
                    if (sw_finish) begin
                        res_max_reg   <= sw_max;
                        res_err_reg   <= 1'b0;
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESULT;
                    end else if (tmo_reg == TMOW'(TIMEOUT - 1)) begin
                        res_max_reg   <= '0;
                        res_err_reg   <= 1'b1;
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESULT;
                    end else if (tmo_reg != '1) begin
                        tmo_reg <= tmo_reg + TMOW'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= CLEAR;
                    end
                end
                CLEAR: begin
                    s_cnt_reg <= '0;
                    t_cnt_reg <= '0;
                    state_reg <= LOAD;
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign busy      = (state_reg != LOAD);
    assign sw_valid  = sw_valid_reg;
    assign sw_data_s = rd_sym[0];
    assign sw_data_t = rd_sym[1];
    assign sw_rst    = sw_rst_reg;
    assign res_valid = res_valid_reg;
    assign res_max   = res_max_reg;
    assign res_err   = res_err_reg;
endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: expected symbols/results are queued at stimulus time
// and popped by a monitor whenever the DUT presents a streamed symbol or an accepted result.
module tb_sw_seq_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sel = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        busy;
    logic        sw_valid;
    logic [1:0]  sw_data_s, sw_data_t;
    logic        sw_rst;
    logic        sw_finish = 1'b0;
    logic [11:0] sw_max = 12'h000;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [11:0] res_max;
    logic        res_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_end = 0;
    int m_cnt [2];
    logic [1:0]  exp_s [$];
    logic [1:0]  exp_t [$];
    logic [12:0] exp_res [$];

    sw_seq_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .busy(busy), .sw_valid(sw_valid),
        .sw_data_s(sw_data_s), .sw_data_t(sw_data_t), .sw_rst(sw_rst),
        .sw_finish(sw_finish), .sw_max(sw_max), .res_valid(res_valid),
        .res_ready(res_ready), .res_max(res_max), .res_err(res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on every streamed symbol and every accepted result.
    always @(negedge clk) begin
        logic [1:0]  es, et;
        logic [12:0] er;
        if (sw_valid) begin
            if (exp_s.size() == 0 || exp_t.size() == 0) begin
                chk("sw_underflow", 1, 0);
            end else begin
                es = exp_s.pop_front();
                et = exp_t.pop_front();
                chk("sw_data_s", int'(sw_data_s), int'(es));
                chk("sw_data_t", int'(sw_data_t), int'(et));
            end
        end
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                chk("res_underflow", 1, 0);
            end else begin
                er = exp_res.pop_front();
                chk("res_err", int'(res_err), int'(er[12]));
                chk("res_max", int'(res_max), int'(er[11:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic sel, input logic [7:0] data);
        logic rdy;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(negedge clk);
        rdy = (m_cnt[sel] != 64);
        chk("in_ready", int'(in_ready), int'(rdy));
        if (rdy) begin
            for (int b = 0; b < 4; b++) begin
                if (sel) exp_t.push_back(data[2*b +: 2]);
                else     exp_s.push_back(data[2*b +: 2]);
            end
            m_cnt[sel]++;
        end
        step();
        in_valid = 1'b0;
        in_sel   = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    // kind 0: all zeros; kind 1: E4 first then interleaved with gaps; kind 2: S full + stalled 65th word.
    task automatic load_job(input int kind);
        for (int i = 0; i < 64; i++) begin
            if (kind == 0) write_word(1'b0, 8'h00);
            if (kind == 1) begin
                gap($urandom_range(0, 2));
                write_word(1'b0, (i == 0) ? 8'hE4 : 8'(i * 37 + 5));
                gap($urandom_range(0, 2));
                write_word(1'b1, 8'(i * 91 + 3));
            end
            if (kind == 2) write_word(1'b0, 8'(i * 13 + 7));
        end
        if (kind == 2) begin
            for (int r = 0; r < 3; r++) write_word(1'b0, 8'hFF);
        end
        if (kind != 1) begin
            for (int i = 0; i < 64; i++)
                write_word(1'b1, (kind == 0) ? 8'h00 : 8'(255 - i));
        end
    endtask

    task automatic stream_phase();
        int k;
        int n;
        k = 0;
        do begin
            step();
            k++;
        end while (!sw_valid && k < 10);
        chk("first_valid_latency", k, 2);
        n = 0;
        while (sw_valid && n < 300) begin
            n++;
            step();
        end
        chk("valid_run_len", n, 256);
        chk("data_zero_after", int'({sw_data_s, sw_data_t}), 0);
        chk("s_left", exp_s.size(), 0);
        chk("t_left", exp_t.size(), 0);
        t_end = cyc;
    endtask

    task automatic sw_respond(input int j, input logic [11:0] v);
        repeat (j - 1) step();
        sw_max = v;
        sw_finish = 1'b1;
        step();
        sw_finish = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int guard;
        guard = 0;
        while (!res_valid && guard < 2000) begin
            step();
            guard++;
        end
        chk("res_latency", cyc - t_end + 1, exp_lat);
    endtask

    task automatic finish_job(input int hold, input logic [11:0] exp_max);
        for (int i = 0; i < hold; i++) begin
            step();
            sw_finish = (i == 4);
            sw_max    = 12'd999;
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_res_max", int'(res_max), int'(exp_max));
        end
        sw_finish = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_drop", int'(res_valid), 0);
        chk("sw_rst_pre", int'(sw_rst), 0);
        step();
        chk("sw_rst_pulse", int'(sw_rst), 1);
        chk("busy_after_clear", int'(busy), 0);
        chk("in_ready_after_clear", int'(in_ready), 1);
        step();
        chk("sw_rst_end", int'(sw_rst), 0);
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sw_rst", int'(sw_rst), 1);
        chk("rst_outputs", int'({sw_valid, sw_data_s, sw_data_t, busy, res_valid, res_err}), 0);
        chk("rst_res_max", int'(res_max), 0);
        reset = 1'b0;
        step();
        chk("post_rst_sw_rst", int'(sw_rst), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Job 1: all zeros, finish after 384 cycles with 2048, result held 10 cycles.
        load_job(0);
        stream_phase();
        exp_res.push_back({1'b0, 12'd2048});
        sw_respond(384, 12'd2048);
        wait_result(385);
        finish_job(10, 12'd2048);

        // Job 2: E4 first, interleaved writes with gaps.
        load_job(1);
        stream_phase();
        exp_res.push_back({1'b0, 12'd777});
        sw_respond(50, 12'd777);
        wait_result(51);
        finish_job(0, 12'd777);

        // Job 3: stalled 65th S word, SW never finishes.
        load_job(2);
        stream_phase();
        sw_max = 12'hABC;
        exp_res.push_back({1'b1, 12'd0});
        wait_result(1024);
        finish_job(2, 12'd0);

        // Job 4: finish on the final timeout cycle wins.
        load_job(0);
        stream_phase();
        exp_res.push_back({1'b0, 12'd1234});
        sw_respond(1023, 12'd1234);
        wait_result(1024);
        finish_job(0, 12'd1234);

        // Job 5: reset during stream cycle 100 aborts the job.
        load_job(1);
        begin
            int k;
            k = 0;
            do begin
                step();
                k++;
            end while (!sw_valid && k < 10);
            chk("abort_first_valid", k, 2);
        end
        repeat (100) step();
        reset = 1'b1;
        step();
        chk("abort_sw_valid", int'(sw_valid), 0);
        chk("abort_sw_rst", int'(sw_rst), 1);
        chk("abort_busy", int'(busy), 0);
        reset = 1'b0;
        exp_s.delete();
        exp_t.delete();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        step();
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_res_valid", int'(res_valid), 0);

        // Job 6: full reload after the abort.
        load_job(1);
        stream_phase();
        exp_res.push_back({1'b0, 12'd4095});
        sw_respond(100, 12'd4095);
        wait_result(101);
        finish_job(0, 12'd4095);

        chk("res_left", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
